// File: rtl/serial_add_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Master drives operands and consumes results; slave is the adder.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one full-adder cell, LSB first,
// WIDTH cycles per operation between two valid/ready handshakes.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic         clock,
  input logic         reset,
  serial_add_if.slave io
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             cy_q, cy_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   sum_ext;

  assign fa_s    = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
  assign fa_co   = (a_sh_q[0] & b_sh_q[0])
                 | (a_sh_q[0] & cy_q)
                 | (b_sh_q[0] & cy_q);
  assign sum_ext = {fa_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cy_d     = cy_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_sh_d   = io.a;
          b_sh_d   = io.b;
          cy_d     = io.c_in;
          cnt_d    = '0;
          sum_sh_d = '0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_ext[WIDTH:1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = fa_co;
        cnt_d    = cnt_q + 1'b1;
        // cy_q is the carry into the MSB on the last bit
        if (cnt_q == CW'(WIDTH - 1)) begin
          ovf_d   = cy_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cy_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cy_q     <= cy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_sh_q;
  assign io.c_out     = cy_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic ci);
    int   t;
    logic [7:0] s;
    logic c, v;
    t = int'(a) + int'(b) + int'(ci);
    s = t[7:0];
    c = (t >= 256);
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {v, c, s};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic ci,
                        input int stall);
    int lat;
    logic [9:0] exp;
    logic [9:0] held;
    exp = model(a, b, ci);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = ci;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, bus.in_ready, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.a    = 8'($urandom);
      bus.b    = 8'($urandom);
      bus.c_in = 1'($urandom);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_result"}, {bus.ovf, bus.c_out, bus.sum}, exp);
    held = {bus.ovf, bus.c_out, bus.sum};
    for (int i = 0; i < stall; i++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      step();
      chk({tag, "_stall_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_stall_ready"}, bus.in_ready, 1'b0);
      chk({tag, "_stall_hold"}, {bus.ovf, bus.c_out, bus.sum}, held);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_post_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       qc[$];
    logic [9:0] expq[$];
    int         acc_t[$];
    int         got;
    int         cyc;
    logic       acc, ohs;
    logic [9:0] obs;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", {bus.ovf, bus.c_out, bus.sum}, 10'h0);

    run_op("basic", 8'h3C, 8'h05, 1'b0, 0);
    run_op("carry1", 8'hFF, 8'h01, 1'b0, 0);
    run_op("carry2", 8'hFF, 8'hFF, 1'b1, 0);
    run_op("ovf1", 8'h7F, 8'h01, 1'b0, 0);
    run_op("ovf2", 8'h80, 8'h80, 1'b0, 0);
    run_op("bp", 8'hA5, 8'h6E, 1'b1, 5);

    // reset in the third RUN cycle of 0x12+0x34
    bus.in_valid = 1'b1;
    bus.a        = 8'h12;
    bus.b        = 8'h34;
    bus.c_in     = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_result", {bus.ovf, bus.c_out, bus.sum}, 10'h0);
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      qa.push_back(8'($urandom));
      qb.push_back(8'($urandom));
      qc.push_back(1'($urandom));
    end
    got = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    while (got < 4 && cyc < 600) begin
      if (qa.size() > 0) begin
        bus.a    = qa[0];
        bus.b    = qb[0];
        bus.c_in = qc[0];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom);
      #1;
      acc = bus.in_valid && bus.in_ready;
      ohs = bus.out_valid && bus.out_ready;
      obs = {bus.ovf, bus.c_out, bus.sum};
      step();
      cyc++;
      if (acc) begin
        expq.push_back(model(qa[0], qb[0], qc[0]));
        acc_t.push_back(cyc);
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(qc.pop_front());
      end
      if (ohs) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected", 1'b1, 1'b0);
        end else begin
          chk("b2b_result", obs, expq.pop_front());
          got++;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_count", got, 4);
    chk("b2b_pending", expq.size(), 0);
    for (int i = 1; i < acc_t.size(); i++) begin
      chk("b2b_spacing", (acc_t[i] - acc_t[i-1]) >= W + 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer: accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready handshake. It adds them LSB-first through a single 1-bit full-add stage, one bit per clock, and presents the registered sum and flags over a second valid/ready handshake. It is the sequencing controller the area-constrained arithmetic path uses in place of a WIDTH-wide ripple adder, trading latency for one full-adder cell.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands a, b, c_in valid this cycle.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A, sampled only on input handshake.
- b  in  WIDTH  operand B, sampled only on input handshake.
- c_in  in  1  carry-in, sampled only on input handshake.
- out_valid  out  1  sum, c_out, ovf valid (high only in DONE).
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; illegal states recover to IDLE on the next edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: load a, b into shift registers, load c_in into the carry flop, clear the bit counter, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: full-add LSB(a_sh), LSB(b_sh), carry.
  - Shift the result bit into sum_sh from the MSB side; shift a_sh and b_sh right by one; register the new carry.
  - On the cycle processing bit WIDTH-1, capture the carry-in to that bit for ovf.
  - Bit counter is $clog2(WIDTH)+1 bits wide and increments each RUN cycle. After WIDTH RUN cycles, go to DONE.
- DONE:
  - out_valid=1.
  - sum, c_out, ovf are driven from registers and held stable until the output handshake.
  - On out_valid&&out_ready, go to IDLE.
- a, b, c_in are don't-care outside the accepting cycle. Changes to them during RUN/DONE must not affect the result.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is informational only and does not alter sum.

## Timing
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0.
  - Bit counter, shift registers and carry are cleared.
- Reset asserted in any state, including mid-RUN or while DONE is stalled, aborts the operation. The in-flight result is discarded with no out_valid pulse, and the reset values above apply from the next cycle.
- Latency:
  - Input handshake at edge k; RUN occupies cycles k+1..k+WIDTH; out_valid rises after edge k+WIDTH.
  - Result is therefore visible WIDTH cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles with out_ready held high (1 IDLE accept + WIDTH RUN + 1 DONE). in_ready rises the cycle after the output handshake.
- Backpressure: DONE persists indefinitely while out_ready=0. in_ready stays 0 for that whole time.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The new operand is accepted no earlier than the following IDLE cycle.
- WIDTH=1: RUN lasts exactly one cycle. ovf equals c_in XOR c_out.

## Test plan
- Basic add, WIDTH=8: a=0x3C, b=0x05, c_in=0, out_ready=1 → out_valid exactly 8 cycles after accept; sum=0x41, c_out=0, ovf=0; in_ready returns after the DONE cycle.
- Carry chain: a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Then a=0xFF, b=0xFF, c_in=1 → sum=0xFF, c_out=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - sum, c_out, ovf must be stable and out_valid stay high throughout; in_ready stays 0.
  - Toggle a and b during RUN/DONE; the result must be unchanged.
- Reset mid-operation: assert reset for one cycle in the 3rd RUN cycle of 0x12+0x34 → next cycle in_ready=1, out_valid=0, sum=0. A fresh 0x12+0x34 then yields 0x46.
- Back-to-back: in_valid held high with 4 random operand sets and a random out_ready pattern.
  - Each result matches a reference model: a+b+c_in mod 256.
  - Carry and ovf are correct.
  - No operand is dropped or duplicated.
  - Spacing is at least 10 cycles per operation.
